// File: rtl/spi_cs_ctrl.sv
// Chip-select sequencer in front of an SPI byte master. It frames a burst of
// 1..MAX_BYTES bytes under one CS_n low window, with setup, hold and gap timing.
module spi_cs_ctrl #(
  parameter int unsigned MAX_BYTES        = 16,
  parameter int unsigned CS_SETUP_CLKS    = 2,
  parameter int unsigned CS_HOLD_CLKS     = 2,
  parameter int unsigned CS_INACTIVE_CLKS = 4,
  localparam int unsigned CW = $clog2(MAX_BYTES + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic          o_Busy,
  input  logic          i_Abort,
  output logic [7:0]    o_M_TX_Byte,
  output logic          o_M_TX_DV,
  input  logic          i_M_TX_Ready,
  input  logic          i_M_RX_DV,
  input  logic [7:0]    i_M_RX_Byte,
  output logic          o_SPI_CS_n
);

  localparam int unsigned T_SH  = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int unsigned T_MAX = (T_SH > CS_INACTIVE_CLKS) ? T_SH : CS_INACTIVE_CLKS;
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP_CLKS - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD_CLKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(CS_INACTIVE_CLKS - 1);
  localparam logic [CW-1:0] MAX_COUNT  = CW'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    NEED_BYTE = 3'd4,
    HOLD      = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] remaining;
  logic [7:0]    tx_byte;
  logic          abort_q;

  // Sequencer; every output is loaded alongside the state it belongs to.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      tcnt        <= '0;
      remaining   <= '0;
      tx_byte     <= 8'h00;
      abort_q     <= 1'b0;
      o_TX_Ready  <= 1'b0;
      o_RX_DV     <= 1'b0;
      o_RX_Byte   <= 8'h00;
      o_Busy      <= 1'b0;
      o_M_TX_Byte <= 8'h00;
      o_M_TX_DV   <= 1'b0;
      o_SPI_CS_n  <= 1'b1;
    end else begin
      o_M_TX_DV <= 1'b0;
      o_RX_DV   <= 1'b0;
      case (state)
        IDLE: begin
          o_TX_Ready <= 1'b1;
          o_Busy     <= 1'b0;
          o_SPI_CS_n <= 1'b1;
          abort_q    <= 1'b0;
          tcnt       <= '0;
          if (i_TX_DV && (i_TX_Count != '0)) begin
            tx_byte    <= i_TX_Byte;
            remaining  <= (i_TX_Count > MAX_COUNT) ? MAX_COUNT : i_TX_Count;
            state      <= SETUP;
            o_TX_Ready <= 1'b0;
            o_Busy     <= 1'b1;
            o_SPI_CS_n <= 1'b0;
          end
        end
        SETUP: begin
          if (i_Abort) begin
            state <= HOLD;
            tcnt  <= '0;
          end else if (tcnt == SETUP_LAST) begin
            state <= ISSUE;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ISSUE: begin
          if (i_Abort) abort_q <= 1'b1;
          if (i_M_TX_Ready) begin
            o_M_TX_DV   <= 1'b1;
            o_M_TX_Byte <= tx_byte;
            state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_Abort) abort_q <= 1'b1;
          if (i_M_RX_DV) begin
            o_RX_DV   <= 1'b1;
            o_RX_Byte <= i_M_RX_Byte;
            remaining <= remaining - CW'(1);
            // A remembered abort only takes effect once the in-flight byte lands.
            if ((remaining == CW'(1)) || abort_q || i_Abort) begin
              state   <= HOLD;
              tcnt    <= '0;
              abort_q <= 1'b0;
            end else begin
              state      <= NEED_BYTE;
              o_TX_Ready <= 1'b1;
            end
          end
        end
        NEED_BYTE: begin
          if (i_Abort) begin
            state      <= HOLD;
            tcnt       <= '0;
            o_TX_Ready <= 1'b0;
          end else if (i_TX_DV) begin
            tx_byte    <= i_TX_Byte;
            state      <= ISSUE;
            o_TX_Ready <= 1'b0;
          end
        end
        HOLD: begin
          if (tcnt == HOLD_LAST) begin
            state      <= GAP;
            tcnt       <= '0;
            o_SPI_CS_n <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP: begin
          if (tcnt == GAP_LAST) begin
            state      <= IDLE;
            tcnt       <= '0;
            o_Busy     <= 1'b0;
            o_TX_Ready <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          tcnt       <= '0;
          o_SPI_CS_n <= 1'b1;
          o_Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Bench for spi_cs_ctrl: byte-master model answering byte^0x99, scoreboard
// queues for issued and received bytes, and per-scenario timing checks.
module tb_spi_cs_ctrl;

  localparam int unsigned MAX_BYTES = 16;
  localparam int unsigned SETUP_C   = 2;
  localparam int unsigned HOLD_C    = 2;
  localparam int unsigned GAP_C     = 4;
  localparam int unsigned CW        = $clog2(MAX_BYTES + 1);
  localparam int          BOUND     = 300;

  localparam int W_READY = 0;
  localparam int W_IDLE  = 1;
  localparam int W_MTX   = 2;
  localparam int W_RX    = 3;
  localparam int W_CSH   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] tx_count;
  logic [7:0]    tx_byte;
  logic          tx_dv;
  logic          abort;
  logic          m_ready;
  logic          m_rx_dv;
  logic [7:0]    m_rx_byte;
  logic          spur_rx;

  logic          o_TX_Ready, o_RX_DV, o_Busy, o_M_TX_DV, o_SPI_CS_n;
  logic [7:0]    o_RX_Byte, o_M_TX_Byte;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [7:0]    exp_mtx[$];
  logic [7:0]    exp_rx[$];
  int            mtx_pulses = 0, rx_pulses = 0, cs_falls = 0, ready_pulses = 0;
  logic          cs_prev = 1'b1, rdy_prev = 1'b0;

  always #5 clk = ~clk;

  spi_cs_ctrl #(
    .MAX_BYTES(MAX_BYTES),
    .CS_SETUP_CLKS(SETUP_C),
    .CS_HOLD_CLKS(HOLD_C),
    .CS_INACTIVE_CLKS(GAP_C)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_TX_Count(tx_count),
    .i_TX_Byte(tx_byte),
    .i_TX_DV(tx_dv),
    .o_TX_Ready(o_TX_Ready),
    .o_RX_DV(o_RX_DV),
    .o_RX_Byte(o_RX_Byte),
    .o_Busy(o_Busy),
    .i_Abort(abort),
    .o_M_TX_Byte(o_M_TX_Byte),
    .o_M_TX_DV(o_M_TX_DV),
    .i_M_TX_Ready(m_ready),
    .i_M_RX_DV(m_rx_dv | spur_rx),
    .i_M_RX_Byte(spur_rx ? 8'hEE : m_rx_byte),
    .o_SPI_CS_n(o_SPI_CS_n)
  );

  // Byte-master model: busy for three cycles after an issue, then returns byte^0x99.
  initial begin : bfm
    int         cnt;
    logic [7:0] b;
    cnt       = 0;
    b         = 8'h00;
    m_ready   = 1'b1;
    m_rx_dv   = 1'b0;
    m_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      m_rx_dv = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          m_rx_dv   = 1'b1;
          m_rx_byte = b ^ 8'h99;
          m_ready   = 1'b1;
        end
      end else if (o_M_TX_DV === 1'b1) begin
        m_ready = 1'b0;
        b       = o_M_TX_Byte;
        cnt     = 3;
      end
    end
  end

  // Scoreboard side: pop expected bytes whenever the DUT pulses.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    logic       rdy;
    if (o_M_TX_DV === 1'b1) begin
      mtx_pulses++;
      n_cmp++;
      if (exp_mtx.size() == 0) begin
        n_err++;
        $display("FAIL mtx_unexpected: issued %02h, expected no issue", o_M_TX_Byte);
      end else begin
        e = exp_mtx.pop_front();
        if (o_M_TX_Byte !== e) begin
          n_err++;
          $display("FAIL mtx_byte: got %02h expected %02h", o_M_TX_Byte, e);
        end
      end
    end
    if (o_RX_DV === 1'b1) begin
      rx_pulses++;
      n_cmp++;
      if (exp_rx.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected: rx %02h, expected no rx", o_RX_Byte);
      end else begin
        e = exp_rx.pop_front();
        if (o_RX_Byte !== e) begin
          n_err++;
          $display("FAIL rx_byte: got %02h expected %02h", o_RX_Byte, e);
        end
      end
    end
    if (cs_prev === 1'b1 && o_SPI_CS_n === 1'b0) cs_falls++;
    cs_prev = o_SPI_CS_n;
    rdy = o_TX_Ready & o_Busy;
    if (rdy === 1'b1 && rdy_prev !== 1'b1) ready_pulses++;
    rdy_prev = rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      W_READY: return o_TX_Ready === 1'b1;
      W_IDLE:  return (o_TX_Ready === 1'b1) && (o_Busy === 1'b0);
      W_MTX:   return o_M_TX_DV === 1'b1;
      W_RX:    return o_RX_DV === 1'b1;
      default: return o_SPI_CS_n === 1'b1;
    endcase
  endfunction

  // Returns ticks taken until the condition holds, or -1 when the bound expires.
  task automatic wait_sig(input int sel, output int n);
    n = 0;
    while (!cond(sel) && n < BOUND) begin
      tick();
      n++;
    end
    if (!cond(sel)) n = -1;
  endtask

  task automatic send(input logic [CW-1:0] cnt, input logic [7:0] b, input bit push);
    tx_count = cnt;
    tx_byte  = b;
    tx_dv    = 1'b1;
    if (push) begin
      exp_mtx.push_back(b);
      exp_rx.push_back(b ^ 8'h99);
    end
    tick();
    tx_dv = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    rst_n    = 1'b0;
    tx_dv    = 1'b0;
    abort    = 1'b0;
    tx_count = '0;
    tx_byte  = 8'h00;
    spur_rx  = 1'b0;
    #23;
    got = {o_SPI_CS_n, o_TX_Ready, o_Busy, o_M_TX_DV, o_RX_DV, o_RX_Byte, o_M_TX_Byte};
    n_cmp++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", got, {1'b1, 20'h00000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({o_TX_Ready, o_Busy, o_SPI_CS_n} !== 3'b101) begin
      n_err++;
      $display("FAIL reset_release: ready/busy/cs got %b expected 101", {o_TX_Ready, o_Busy, o_SPI_CS_n});
    end
  endtask

  task automatic test_single();
    int n;
    int f0;
    wait_sig(W_IDLE, n);
    f0 = cs_falls;
    send(CW'(1), 8'hA5, 1'b1);
    n_cmp++;
    if ({o_SPI_CS_n, o_Busy} !== 2'b01) begin
      n_err++;
      $display("FAIL single_cs_fall: cs/busy got %b expected 01", {o_SPI_CS_n, o_Busy});
    end
    wait_sig(W_MTX, n);
    n_cmp++;
    if (n != int'(SETUP_C) + 1 || o_M_TX_Byte !== 8'hA5) begin
      n_err++;
      $display("FAIL single_issue: %0d clks byte %02h, expected %0d clks byte a5", n, o_M_TX_Byte, SETUP_C + 1);
    end
    wait_sig(W_RX, n);
    n_cmp++;
    if (n < 0 || o_RX_Byte !== 8'h3C) begin
      n_err++;
      $display("FAIL single_rx: wait %0d byte %02h, expected byte 3c", n, o_RX_Byte);
    end
    wait_sig(W_CSH, n);
    n_cmp++;
    if (n != int'(HOLD_C)) begin
      n_err++;
      $display("FAIL single_hold: %0d clks expected %0d", n, HOLD_C);
    end
    wait_sig(W_READY, n);
    n_cmp++;
    if (n != int'(GAP_C) || o_SPI_CS_n !== 1'b1 || o_Busy !== 1'b0 || cs_falls != f0 + 1) begin
      n_err++;
      $display("FAIL single_gap: %0d clks cs %b busy %b falls %0d, expected %0d clks cs 1 busy 0 falls 1",
               n, o_SPI_CS_n, o_Busy, cs_falls - f0, GAP_C);
    end
  endtask

  task automatic test_multi();
    int n;
    int m0, r0, f0, p0;
    bit cs_ok;
    wait_sig(W_IDLE, n);
    m0 = mtx_pulses; r0 = rx_pulses; f0 = cs_falls; p0 = ready_pulses;
    cs_ok = 1'b1;
    send(CW'(3), 8'h01, 1'b1);
    for (int i = 2; i <= 3; i++) begin
      wait_sig(W_READY, n);
      if (n < 0 || o_SPI_CS_n !== 1'b0) cs_ok = 1'b0;
      send(CW'(7), 8'(i), 1'b1);
    end
    wait_sig(W_IDLE, n);
    n_cmp++;
    if (!cs_ok || n < 0) begin
      n_err++;
      $display("FAIL multi_need_byte: ready seen with cs low %0d, idle wait %0d", cs_ok, n);
    end
    n_cmp++;
    if (mtx_pulses - m0 != 3 || rx_pulses - r0 != 3) begin
      n_err++;
      $display("FAIL multi_counts: issues %0d rx %0d expected 3 and 3", mtx_pulses - m0, rx_pulses - r0);
    end
    n_cmp++;
    if (cs_falls - f0 != 1 || ready_pulses - p0 != 2) begin
      n_err++;
      $display("FAIL multi_window: cs falls %0d ready pulses %0d expected 1 and 2", cs_falls - f0, ready_pulses - p0);
    end
  endtask

  task automatic test_clamp();
    int n;
    int m0, p0;
    bit quiet;
    wait_sig(W_IDLE, n);
    send(CW'(0), 8'h55, 1'b0);
    quiet = 1'b1;
    repeat (6) begin
      if (o_SPI_CS_n !== 1'b1 || o_Busy !== 1'b0 || o_TX_Ready !== 1'b1) quiet = 1'b0;
      tick();
    end
    n_cmp++;
    if (!quiet) begin
      n_err++;
      $display("FAIL zero_count: cs/busy/ready got %b expected 101", {o_SPI_CS_n, o_Busy, o_TX_Ready});
    end
    m0 = mtx_pulses; p0 = ready_pulses;
    send(CW'(20), 8'h10, 1'b1);
    for (int i = 1; i < int'(MAX_BYTES); i++) begin
      wait_sig(W_READY, n);
      send(CW'(0), 8'(8'h10 + i), 1'b1);
    end
    wait_sig(W_IDLE, n);
    n_cmp++;
    if (n < 0 || mtx_pulses - m0 != int'(MAX_BYTES) || ready_pulses - p0 != int'(MAX_BYTES) - 1) begin
      n_err++;
      $display("FAIL clamp: issues %0d ready pulses %0d idle %0d, expected %0d and %0d",
               mtx_pulses - m0, ready_pulses - p0, n, MAX_BYTES, MAX_BYTES - 1);
    end
  endtask

  task automatic test_abort_need();
    int n, h;
    int m0, r0;
    wait_sig(W_IDLE, n);
    m0 = mtx_pulses; r0 = rx_pulses;
    send(CW'(4), 8'h40, 1'b1);
    wait_sig(W_READY, n);
    abort    = 1'b1;
    tx_byte  = 8'h41;
    tx_count = CW'(0);
    tx_dv    = 1'b1;
    tick();
    abort = 1'b0;
    tx_dv = 1'b0;
    n_cmp++;
    if ({o_TX_Ready, o_SPI_CS_n, o_Busy} !== 3'b001) begin
      n_err++;
      $display("FAIL abort_need_state: ready/cs/busy got %b expected 001", {o_TX_Ready, o_SPI_CS_n, o_Busy});
    end
    wait_sig(W_CSH, h);
    wait_sig(W_READY, n);
    n_cmp++;
    if (h != int'(HOLD_C) || n != int'(GAP_C)) begin
      n_err++;
      $display("FAIL abort_need_timing: hold %0d gap %0d expected %0d and %0d", h, n, HOLD_C, GAP_C);
    end
    n_cmp++;
    if (mtx_pulses - m0 != 1 || rx_pulses - r0 != 1) begin
      n_err++;
      $display("FAIL abort_need_issues: issues %0d rx %0d expected 1 and 1", mtx_pulses - m0, rx_pulses - r0);
    end
  endtask

  task automatic test_abort_wait();
    int n, r, h;
    int m0, r0, p0;
    wait_sig(W_IDLE, n);
    m0 = mtx_pulses; r0 = rx_pulses; p0 = ready_pulses;
    send(CW'(3), 8'h60, 1'b1);
    wait_sig(W_MTX, n);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_sig(W_RX, r);
    n_cmp++;
    if (r < 0 || o_SPI_CS_n !== 1'b0 || o_RX_Byte !== 8'hF9) begin
      n_err++;
      $display("FAIL abort_wait_rx: wait %0d cs %b byte %02h, expected cs 0 byte f9", r, o_SPI_CS_n, o_RX_Byte);
    end
    wait_sig(W_CSH, h);
    wait_sig(W_READY, n);
    n_cmp++;
    if (h != int'(HOLD_C) || n != int'(GAP_C)) begin
      n_err++;
      $display("FAIL abort_wait_timing: hold %0d gap %0d expected %0d and %0d", h, n, HOLD_C, GAP_C);
    end
    n_cmp++;
    if (mtx_pulses - m0 != 1 || rx_pulses - r0 != 1 || ready_pulses - p0 != 0) begin
      n_err++;
      $display("FAIL abort_wait_counts: issues %0d rx %0d ready %0d expected 1 1 0",
               mtx_pulses - m0, rx_pulses - r0, ready_pulses - p0);
    end
  endtask

  task automatic test_spurious();
    int n;
    int r0;
    logic [7:0] keep;
    wait_sig(W_IDLE, n);
    r0   = rx_pulses;
    keep = o_RX_Byte;
    spur_rx = 1'b1;
    tick();
    spur_rx = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (o_RX_Byte !== keep || rx_pulses != r0 || o_Busy !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_rx: byte %02h rx %0d busy %b, expected byte %02h rx 0 busy 0",
               o_RX_Byte, rx_pulses - r0, o_Busy, keep);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int m0, r0;
    wait_sig(W_IDLE, n);
    send(CW'(3), 8'h70, 1'b1);
    wait_sig(W_READY, n);
    send(CW'(0), 8'h71, 1'b1);
    wait_sig(W_MTX, n);
    #2;
    rst_n = 1'b0;
    exp_mtx.delete();
    exp_rx.delete();
    #1;
    n_cmp++;
    if ({o_SPI_CS_n, o_Busy, o_TX_Ready, o_M_TX_DV} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_mid: cs/busy/ready/mtxdv got %b expected 1000",
               {o_SPI_CS_n, o_Busy, o_TX_Ready, o_M_TX_DV});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m0 = mtx_pulses; r0 = rx_pulses;
    tick();
    send(CW'(1), 8'h81, 1'b1);
    wait_sig(W_IDLE, n);
    n_cmp++;
    if (n < 0 || mtx_pulses - m0 != 1 || rx_pulses - r0 != 1) begin
      n_err++;
      $display("FAIL reset_recover: idle %0d issues %0d rx %0d expected 1 and 1", n, mtx_pulses - m0, rx_pulses - r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_clamp();
    test_abort_need();
    test_abort_wait();
    test_spurious();
    test_reset_mid();
    repeat (4) tick();
    n_cmp++;
    if (exp_mtx.size() + exp_rx.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d issues and %0d rx outstanding, expected 0", exp_mtx.size(), exp_rx.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cs_ctrl.md
SPI_CS_CTRL -- requirements
Module: spi_cs_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16, the maximum number of bytes per chip-select assertion.
REQ-002 SHALL have parameter CS_SETUP_CLKS, default 2 (legal values >= 1), the i_Clk cycles from CS_n falling to the first byte issue.
REQ-003 SHALL have parameter CS_HOLD_CLKS, default 2 (>= 1), the i_Clk cycles from the last byte done to CS_n rising.
REQ-004 SHALL have parameter CS_INACTIVE_CLKS, default 4 (>= 1), the minimum number of i_Clk cycles CS_n stays high between transactions.
REQ-005 SHALL have ports: i_Clk in 1, the single clock; i_Rst_L in 1, asynchronous active-low reset.
REQ-006 SHALL have user-side ports:
- i_TX_Count in CW=$clog2(MAX_BYTES+1): bytes in the transaction, sampled on the first byte only.
- i_TX_Byte in 8: byte to send.
- i_TX_DV in 1: single-cycle valid pulse for i_TX_Byte.
- o_TX_Ready out 1: controller accepts i_TX_DV this cycle.
- o_RX_DV out 1: single-cycle received-byte valid.
- o_RX_Byte out 8: received byte.
- o_Busy out 1: a transaction is in progress.
- i_Abort in 1: ends the transaction early.
REQ-007 SHALL have byte-master-side ports:
- o_M_TX_Byte out 8 and o_M_TX_DV out 1: byte and issue pulse to the SPI byte master.
- i_M_TX_Ready in 1: byte master is idle.
- i_M_RX_DV in 1 and i_M_RX_Byte in 8: byte-done pulse and received data.
- o_SPI_CS_n out 1: active-low chip select.

Function
REQ-008 SHALL implement the states IDLE, SETUP, ISSUE, WAIT_DONE, NEED_BYTE, HOLD and GAP.
REQ-009 IDLE SHALL drive o_TX_Ready=1, o_Busy=0 and o_SPI_CS_n=1.
- i_TX_DV with a nonzero i_TX_Count SHALL latch the byte and the count, then go to SETUP.
- i_TX_DV with i_TX_Count=0 SHALL be ignored.
REQ-010 A count above MAX_BYTES SHALL be clamped to MAX_BYTES.
REQ-011 SETUP SHALL drive o_SPI_CS_n=0 and wait exactly CS_SETUP_CLKS cycles, then go to ISSUE.
REQ-012 ISSUE SHALL wait for i_M_TX_Ready=1.
- On the following cycle it SHALL drive o_M_TX_DV=1 for exactly one cycle, with o_M_TX_Byte holding the latched byte.
- It SHALL then go to WAIT_DONE.
REQ-013 o_M_TX_Byte SHALL remain stable from the issue pulse until the next latch.
REQ-014 WAIT_DONE SHALL handle i_M_RX_DV as follows:
- It SHALL register i_M_RX_Byte into o_RX_Byte and pulse o_RX_DV one cycle later.
- It SHALL decrement the remaining count.
- It SHALL go to NEED_BYTE if the remaining count is nonzero, else to HOLD.
REQ-015 NEED_BYTE SHALL drive o_TX_Ready=1 and keep o_SPI_CS_n=0.
- i_TX_DV SHALL latch the byte and go to ISSUE.
- i_TX_Count SHALL be ignored in this state.
REQ-016 o_TX_Ready SHALL be 0 in SETUP, ISSUE, WAIT_DONE, HOLD and GAP, and i_TX_DV SHALL be ignored there.
REQ-017 HOLD SHALL keep o_SPI_CS_n=0 for exactly CS_HOLD_CLKS cycles, then go to GAP.
REQ-018 GAP SHALL drive o_SPI_CS_n=1 for exactly CS_INACTIVE_CLKS cycles, then go to IDLE.
REQ-019 o_Busy SHALL be 1 in every state except IDLE.
REQ-020 i_Abort handling:
- In SETUP or NEED_BYTE, i_Abort SHALL go to HOLD (no further byte issued).
- In ISSUE or WAIT_DONE, i_Abort SHALL be remembered, and the in-flight byte SHALL complete (o_RX_DV still pulses) before going to HOLD.
- In IDLE, HOLD and GAP, i_Abort SHALL be ignored.
REQ-021 i_Abort and i_TX_DV in the same NEED_BYTE cycle: abort SHALL win and the byte SHALL be dropped.
REQ-022 i_M_RX_DV outside WAIT_DONE SHALL be ignored: no o_RX_DV and no count change.
REQ-023 All outputs SHALL be registered.
REQ-024 The CS timing counters SHALL be sized for max(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_INACTIVE_CLKS) and SHALL NOT wrap.

Reset
REQ-025 Assertion of i_Rst_L=0 SHALL asynchronously force:
- the state to IDLE;
- o_SPI_CS_n=1, o_TX_Ready=0 (1 from the first clock after release), o_Busy=0;
- o_M_TX_DV=0, o_RX_DV=0;
- o_RX_Byte=0x00, o_M_TX_Byte=0x00;
- all counters to 0 and the abort flag to 0.
REQ-026 Reset mid-transaction SHALL raise o_SPI_CS_n immediately, with no HOLD or GAP sequence.

Verification
REQ-027 Count=1, byte 0xA5, MISO model returns 0x3C -> bench SHALL check:
- CS_n falls one clock after the DV;
- o_M_TX_DV fires after 2 setup clocks plus the ready wait, with byte 0xA5;
- o_RX_DV carries 0x3C;
- CS_n rises 2 clocks after the RX_DV, then stays high 4 clocks before o_TX_Ready=1.
REQ-028 Count=3, bytes 0x01/0x02/0x03 -> bench SHALL check:
- three o_M_TX_DV pulses in order under a single CS_n low window;
- o_TX_Ready pulses only in NEED_BYTE, twice;
- exactly three o_RX_DV.
REQ-029 Count=0, then count=20 with MAX_BYTES=16 -> bench SHALL check:
- the first is ignored (CS_n stays 1);
- the second runs exactly 16 bytes.
REQ-030 Abort during NEED_BYTE after byte 1 of 4 -> bench SHALL check no second issue and the HOLD then GAP timing.
- Abort during WAIT_DONE -> the byte completes with o_RX_DV before HOLD.
REQ-031 i_Rst_L pulsed low during WAIT_DONE of byte 2 -> bench SHALL check:
- CS_n=1 asynchronously, o_Busy=0;
- a subsequent count=1 transaction completes normally.
